// File: rtl/relu_stream_ctrl.sv
// ReLU pass sequencer: streams N signed elements from a source RAM through ReLU into a destination RAM.
// Define RELU_CLIP_EN to build the bounded variant that saturates positive results at CLIP_MAX.
module relu_stream_ctrl #(
    parameter int DW       = 10,
    parameter int AW       = 8,
    parameter int CLIP_MAX = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] wr_base,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   pos_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t        state, state_nxt;
    logic [AW:0]   rd_left;   // reads still to issue, including the one on the bus
    logic [AW-1:0] wr_ptr;
    logic          rd_vld;    // rd_data holds a requested element this cycle
    logic          is_pos;
    logic [DW-1:0] act;

    assign is_pos = ($signed(rd_data) > $signed({DW{1'b0}}));

`ifdef RELU_CLIP_EN
    localparam logic signed [DW-1:0] CLIP_T = DW'(CLIP_MAX);
`else
    logic unused_clip;
    assign unused_clip = ^CLIP_MAX;
`endif

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        act = '0;
        if (is_pos) begin
`ifdef RELU_CLIP_EN
            if ($signed(rd_data) > CLIP_T)
                act = CLIP_T;
            else
                act = rd_data;
`else
            act = rd_data;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? FIN : RUN;
            RUN:     if (rd_left == (AW+1)'(1)) state_nxt = DRAIN;
            DRAIN:   if (wr_en && !rd_vld) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rd_left <= '0;
            rd_vld  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_ptr  <= '0;
            pos_cnt <= '0;
        end else begin
            // Two-stage pipe: read strobe -> data valid -> write strobe.
            rd_en  <= (state_nxt == RUN);
            rd_vld <= rd_en;
            wr_en  <= rd_vld;

            if (rd_vld) begin
                wr_data <= act;
                wr_addr <= wr_ptr;
                wr_ptr  <= wr_ptr + 1'b1;
                if (is_pos)
                    pos_cnt <= pos_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr <= rd_base;
                        rd_left <= len;
                        wr_ptr  <= wr_base;
                        pos_cnt <= '0;
                    end
                end
                RUN: begin
                    rd_left <= rd_left - 1'b1;
                    if (rd_left != (AW+1)'(1))
                        rd_addr <= rd_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Directed bench for relu_stream_ctrl: cycle-accurate strobes, addressing, ReLU values and pos_cnt.
// Cycle k is the period after the k-th rising edge, with start sampled at edge 0; outputs sampled on falling edges.
module tb_relu_stream_ctrl;

    localparam int DW = 10;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] rd_base = '0;
    logic [AW-1:0] wr_base = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   pos_cnt;

    relu_stream_ctrl #(.DW(DW), .AW(AW), .CLIP_MAX(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .rd_base(rd_base), .wr_base(wr_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .pos_cnt(pos_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_mem [0:(1<<AW)-1];
    always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

    int errors = 0;
    int checks = 0;

    int            rd_n, rd_first, wr_n, busy_n, busy_first, busy_last, done_n, done_cyc;
    int            wr_cyc_q[$];
    logic [AW-1:0] rd_adr_q[$];
    logic [AW-1:0] wr_adr_q[$];
    logic [DW-1:0] wr_dat_q[$];
    logic [AW:0]   pos_at_done;

    task automatic clear_rec();
        rd_n = 0; rd_first = -1; wr_n = 0; busy_n = 0; busy_first = -1; busy_last = -1;
        done_n = 0; done_cyc = -1; pos_at_done = '1;
        wr_cyc_q.delete(); rd_adr_q.delete(); wr_adr_q.delete(); wr_dat_q.delete();
    endtask

    // Pulse start, scramble the pass inputs right after, and log every output for ncyc cycles.
    task automatic run_pass(input int n, input int rb, input int wb, input int ncyc, input int restart_cyc);
        clear_rec();
        @(negedge clk);
        len = (AW+1)'(n); rd_base = AW'(rb); wr_base = AW'(wb); start = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            if (cyc == 1) begin
                len = (AW+1)'(9); rd_base = AW'(100); wr_base = AW'(200);
            end
            if (rd_en) begin
                rd_n++; rd_adr_q.push_back(rd_addr);
                if (rd_first < 0) rd_first = cyc;
            end
            if (wr_en) begin
                wr_n++; wr_cyc_q.push_back(cyc); wr_adr_q.push_back(wr_addr); wr_dat_q.push_back(wr_data);
            end
            if (busy) begin
                busy_n++; busy_last = cyc;
                if (busy_first < 0) busy_first = cyc;
            end
            if (done) begin
                done_n++; done_cyc = cyc; pos_at_done = pos_cnt;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data, pos_cnt} !== '0) begin
            errors++; $display("FAIL reset_hold: outputs=%h want all zero",
                               {rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data, pos_cnt});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_en, wr_en, busy, done, pos_cnt} !== '0) begin
            errors++; $display("FAIL reset_idle: outputs=%h want all zero", {rd_en, wr_en, busy, done, pos_cnt});
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d [4];
        exp_d = '{DW'(5), DW'(0), DW'(0), DW'(511)};
        src_mem[0] = DW'(5); src_mem[1] = DW'(-3); src_mem[2] = DW'(0); src_mem[3] = DW'(511);
        run_pass(4, 0, 16, 10, 0);
        checks++; if (rd_n !== 4 || rd_first !== 1) begin errors++; $display("FAIL basic_rd: n=%0d first=%0d want 4/1", rd_n, rd_first); end
        for (int i = 0; i < 4 && i < rd_adr_q.size(); i++) begin
            checks++; if (rd_adr_q[i] !== AW'(i)) begin errors++; $display("FAIL basic_rd_addr[%0d]: got %0d want %0d", i, rd_adr_q[i], i); end
        end
        checks++; if (wr_n !== 4) begin errors++; $display("FAIL basic_wr_n: got %0d want 4", wr_n); end
        for (int i = 0; i < 4 && i < wr_dat_q.size(); i++) begin
            checks++;
            if (wr_cyc_q[i] !== 3 + i || wr_adr_q[i] !== AW'(16 + i) || wr_dat_q[i] !== exp_d[i]) begin
                errors++; $display("FAIL basic_wr[%0d]: cyc=%0d addr=%0d data=%0d want %0d/%0d/%0d",
                                   i, wr_cyc_q[i], wr_adr_q[i], wr_dat_q[i], 3 + i, 16 + i, exp_d[i]);
            end
        end
        checks++; if (busy_first !== 1 || busy_last !== 6 || busy_n !== 6) begin
            errors++; $display("FAIL basic_busy: first=%0d last=%0d n=%0d want 1/6/6", busy_first, busy_last, busy_n); end
        checks++; if (done_n !== 1 || done_cyc !== 7) begin errors++; $display("FAIL basic_done: n=%0d cyc=%0d want 1/7", done_n, done_cyc); end
        checks++; if (pos_at_done !== (AW+1)'(2)) begin errors++; $display("FAIL basic_pos: got %0d want 2", pos_at_done); end
        checks++; if (pos_cnt !== (AW+1)'(2)) begin errors++; $display("FAIL basic_pos_hold: got %0d want 2", pos_cnt); end
    endtask

    task automatic test_negative();
        logic [DW-1:0] exp_d [3];
        exp_d = '{DW'(0), DW'(0), DW'(1)};
        src_mem[32] = DW'(-512); src_mem[33] = DW'(-1); src_mem[34] = DW'(1);
        run_pass(3, 32, 48, 9, 0);
        checks++; if (wr_n !== 3) begin errors++; $display("FAIL neg_wr_n: got %0d want 3", wr_n); end
        for (int i = 0; i < 3 && i < wr_dat_q.size(); i++) begin
            checks++;
            if (wr_adr_q[i] !== AW'(48 + i) || wr_dat_q[i] !== exp_d[i]) begin
                errors++; $display("FAIL neg_wr[%0d]: addr=%0d data=%0d want %0d/%0d", i, wr_adr_q[i], wr_dat_q[i], 48 + i, exp_d[i]);
            end
        end
        checks++; if (done_n !== 1 || done_cyc !== 6) begin errors++; $display("FAIL neg_done: n=%0d cyc=%0d want 1/6", done_n, done_cyc); end
        checks++; if (pos_at_done !== (AW+1)'(1)) begin errors++; $display("FAIL neg_pos: got %0d want 1", pos_at_done); end
    endtask

    task automatic test_len_zero();
        run_pass(0, 5, 5, 6, 0);
        checks++; if (rd_n !== 0 || wr_n !== 0) begin errors++; $display("FAIL zero_strobes: rd=%0d wr=%0d want 0/0", rd_n, wr_n); end
        checks++; if (busy_n !== 0) begin errors++; $display("FAIL zero_busy: got %0d cycles want 0", busy_n); end
        checks++; if (done_n !== 1 || done_cyc !== 1) begin errors++; $display("FAIL zero_done: n=%0d cyc=%0d want 1/1", done_n, done_cyc); end
        checks++; if (pos_at_done !== '0) begin errors++; $display("FAIL zero_pos: got %0d want 0", pos_at_done); end
    endtask

    task automatic test_wrap_restart();
        logic [AW-1:0] exp_ra [4];
        logic [AW-1:0] exp_wa [4];
        logic [DW-1:0] exp_d  [4];
        exp_ra = '{AW'(254), AW'(255), AW'(0), AW'(1)};
        exp_wa = '{AW'(255), AW'(0), AW'(1), AW'(2)};
        exp_d  = '{DW'(1), DW'(2), DW'(0), DW'(300)};
        src_mem[254] = DW'(1); src_mem[255] = DW'(2); src_mem[0] = DW'(-4); src_mem[1] = DW'(300);
        run_pass(4, 254, 255, 14, 3);
        checks++; if (rd_n !== 4 || wr_n !== 4) begin errors++; $display("FAIL wrap_n: rd=%0d wr=%0d want 4/4", rd_n, wr_n); end
        for (int i = 0; i < 4 && i < rd_adr_q.size() && i < wr_dat_q.size(); i++) begin
            checks++;
            if (rd_adr_q[i] !== exp_ra[i] || wr_adr_q[i] !== exp_wa[i] || wr_dat_q[i] !== exp_d[i]) begin
                errors++; $display("FAIL wrap[%0d]: ra=%0d wa=%0d data=%0d want %0d/%0d/%0d",
                                   i, rd_adr_q[i], wr_adr_q[i], wr_dat_q[i], exp_ra[i], exp_wa[i], exp_d[i]);
            end
        end
        checks++; if (done_n !== 1 || done_cyc !== 7) begin errors++; $display("FAIL wrap_done: n=%0d cyc=%0d want 1/7", done_n, done_cyc); end
        checks++; if (pos_at_done !== (AW+1)'(3)) begin errors++; $display("FAIL wrap_pos: got %0d want 3", pos_at_done); end
    endtask

    task automatic test_reset_mid();
        int act_n;
        logic [DW-1:0] exp_d [2];
        exp_d = '{DW'(10), DW'(0)};
        for (int i = 0; i < 8; i++) src_mem[i] = DW'(10 + i);
        @(negedge clk);
        len = (AW+1)'(8); rd_base = '0; wr_base = AW'(64); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wr_en !== 1'b1 || wr_data !== DW'(10)) begin
            errors++; $display("FAIL rst_pre: wr_en=%b data=%0d want 1/10", wr_en, wr_data); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data, pos_cnt} !== '0) begin
            errors++; $display("FAIL rst_mid: outputs=%h want all zero",
                               {rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data, pos_cnt});
        end
        @(negedge clk); rst_n = 1'b1;
        act_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_en || wr_en || done || busy) act_n++;
        end
        checks++; if (act_n !== 0) begin errors++; $display("FAIL rst_quiet: active cycles=%0d want 0", act_n); end
        src_mem[0] = DW'(10); src_mem[1] = DW'(-7);
        run_pass(2, 0, 0, 8, 0);
        checks++; if (wr_n !== 2) begin errors++; $display("FAIL rst_after_wr_n: got %0d want 2", wr_n); end
        for (int i = 0; i < 2 && i < wr_dat_q.size(); i++) begin
            checks++; if (wr_dat_q[i] !== exp_d[i] || wr_adr_q[i] !== AW'(i)) begin
                errors++; $display("FAIL rst_after_wr[%0d]: addr=%0d data=%0d want %0d/%0d", i, wr_adr_q[i], wr_dat_q[i], i, exp_d[i]); end
        end
        checks++; if (done_n !== 1 || done_cyc !== 5) begin errors++; $display("FAIL rst_after_done: n=%0d cyc=%0d want 1/5", done_n, done_cyc); end
        checks++; if (pos_at_done !== (AW+1)'(1)) begin errors++; $display("FAIL rst_after_pos: got %0d want 1", pos_at_done); end
    endtask

    task automatic test_clip();
        logic [DW-1:0] exp_d [4];
`ifdef RELU_CLIP_EN
        exp_d = '{DW'(6), DW'(6), DW'(0), DW'(3)};
`else
        exp_d = '{DW'(7), DW'(6), DW'(0), DW'(3)};
`endif
        src_mem[8] = DW'(7); src_mem[9] = DW'(6); src_mem[10] = DW'(-2); src_mem[11] = DW'(3);
        run_pass(4, 8, 20, 10, 0);
        checks++; if (wr_n !== 4) begin errors++; $display("FAIL clip_wr_n: got %0d want 4", wr_n); end
        for (int i = 0; i < 4 && i < wr_dat_q.size(); i++) begin
            checks++; if (wr_dat_q[i] !== exp_d[i]) begin
                errors++; $display("FAIL clip_wr[%0d]: data=%0d want %0d", i, wr_dat_q[i], exp_d[i]); end
        end
        checks++; if (done_cyc !== 7 || pos_at_done !== (AW+1)'(3)) begin
            errors++; $display("FAIL clip_done_pos: cyc=%0d pos=%0d want 7/3", done_cyc, pos_at_done); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) src_mem[i] = '0;
        test_reset();
        test_basic();
        test_negative();
        test_len_zero();
        test_wrap_restart();
        test_reset_mid();
        test_clip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
